ele_cfg_loader: RTL and testbench

Buffers the 1024-bit electrode mux configuration, written 16 bits per command from the SPI command bus (code/addr/data_in) decoded in MAIN_FSM. On a commit command it optionally pulses the probe reset, then shifts the whole image serially into the probe-side electrode shift register on data_to_elec/clk_to_elec. It sits between MAIN_FSM and the probe pins, replacing ad-hoc shifting in the top FSM. One instance drives the recording electrode chain; a second instance drives the chem chain.

---
 rtl/ele_cfg_loader_pkg.sv | 30 +++
 rtl/ele_shift_tx.sv | 107 ++++++++++
 rtl/ele_cfg_loader.sv | 89 ++++++++
 tb/tb_ele_cfg_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ele_cfg_loader_pkg.sv
// Shared constants for the electrode configuration loader and MAIN_FSM command decode.
package ele_cfg_loader_pkg;

    localparam int unsigned ELE_NUM       = 1024;
    localparam int unsigned ELE_GROUP_WID = 16;
    localparam int unsigned SPI_ADDR_LEN  = 10;
    localparam int unsigned SPI_DATA_LEN  = 16;
    localparam int unsigned SPI_CODE_LEN  = 6;

    localparam int unsigned NUM_GROUPS = ELE_NUM / ELE_GROUP_WID;
    localparam int unsigned GRP_IDX_W  = $clog2(NUM_GROUPS);
    localparam int unsigned BIT_IDX_W  = $clog2(ELE_GROUP_WID);
    localparam int unsigned ELE_IDX_W  = $clog2(ELE_NUM);

    localparam logic [SPI_ADDR_LEN-1:0] BASE_ADDR = 10'h100;
    localparam logic [SPI_ADDR_LEN-1:0] GRP_SPAN  = SPI_ADDR_LEN'(NUM_GROUPS);

    localparam logic [SPI_CODE_LEN-1:0] CODE_WR     = 6'h01;
    localparam logic [SPI_CODE_LEN-1:0] CODE_RD     = 6'h02;
    localparam logic [SPI_CODE_LEN-1:0] CODE_COMMIT = 6'h03;

    typedef enum logic [2:0] {
        StIdle,
        StPrbRst,
        StShiftLo,
        StShiftHi,
        StFinish
    } load_state_e;

endpackage

// File: rtl/ele_shift_tx.sv
// Serial transmitter for the probe electrode chain: optional probe reset, then one bit per
// divided clock period, element 0 first.
module ele_shift_tx
    import ele_cfg_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned RST_CYC = 8
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 prb_rst,
    input  logic                 bit_in,
    output logic [ELE_IDX_W-1:0] bit_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 clk_to_elec,
    output logic                 data_to_elec,
    output logic                 rst_n_to_probe
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);

    load_state_e          state_q;
    logic [ELE_IDX_W-1:0] cnt_q;
    logic [15:0]          div_q;
    logic                 last;

    assign last = (cnt_q == ELE_IDX_W'(ELE_NUM - 1));
    // Look one bit ahead in SHIFT_HI so bit_in is ready at the SHIFT_LO entry.
    assign bit_idx = (state_q == StShiftHi) ? cnt_q + ELE_IDX_W'(1) : cnt_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            div_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            clk_to_elec    <= 1'b0;
            data_to_elec   <= 1'b0;
            rst_n_to_probe <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cnt_q <= '0;
                        div_q <= '0;
                        if (prb_rst) begin
                            rst_n_to_probe <= 1'b0;
                            state_q        <= StPrbRst;
                        end else begin
                            data_to_elec <= bit_in;
                            state_q      <= StShiftLo;
                        end
                    end
                end
                StPrbRst: begin
                    if (div_q == RST_LAST) begin
                        div_q          <= '0;
                        rst_n_to_probe <= 1'b1;
                        data_to_elec   <= bit_in;
                        state_q        <= StShiftLo;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                StShiftLo: begin
                    if (div_q == DIV_LAST) begin
                        div_q       <= '0;
                        clk_to_elec <= 1'b1;
                        state_q     <= StShiftHi;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                StShiftHi: begin
                    if (div_q == DIV_LAST) begin
                        div_q       <= '0;
                        clk_to_elec <= 1'b0;
                        if (last) begin
                            data_to_elec <= 1'b0;
                            state_q      <= StFinish;
                        end else begin
                            cnt_q        <= cnt_q + ELE_IDX_W'(1);
                            data_to_elec <= bit_in;
                            state_q      <= StShiftLo;
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                StFinish: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/ele_cfg_loader.sv
// Electrode mux configuration buffer: 64 x 16-bit groups written over the SPI command bus,
// committed serially to the probe chain by ele_shift_tx.
module ele_cfg_loader
    import ele_cfg_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned RST_CYC = 8
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [SPI_CODE_LEN-1:0] code,
    input  logic [SPI_ADDR_LEN-1:0] addr,
    input  logic [SPI_DATA_LEN-1:0] data_in,
    output logic [SPI_DATA_LEN-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    data_to_elec,
    output logic                    clk_to_elec,
    output logic                    rst_n_to_probe
);

    logic [ELE_GROUP_WID-1:0] cfg_mem [NUM_GROUPS];

    logic [SPI_ADDR_LEN-1:0] grp_off;
    logic [GRP_IDX_W-1:0]    grp_idx;
    logic                    in_range;
    logic                    is_wr, is_rd, is_commit;
    logic                    wr_ok, rd_ok, start, cmd_err;
    logic [ELE_IDX_W-1:0]    bit_idx;
    logic                    bit_sel;

    assign grp_off  = addr - BASE_ADDR;
    assign grp_idx  = grp_off[GRP_IDX_W-1:0];
    assign in_range = (addr >= BASE_ADDR) && (grp_off < GRP_SPAN);

    assign is_wr     = cmd_valid && (code == CODE_WR);
    assign is_rd     = cmd_valid && (code == CODE_RD);
    assign is_commit = cmd_valid && (code == CODE_COMMIT);

    // The buffer is frozen while busy so the image being shifted stays consistent.
    assign wr_ok   = is_wr && in_range && !busy;
    assign rd_ok   = is_rd && in_range;
    assign start   = is_commit && !busy;
    assign cmd_err = (is_wr && !(in_range && !busy)) || (is_rd && !in_range) ||
                     (is_commit && busy);

    assign bit_sel = cfg_mem[bit_idx[ELE_IDX_W-1:BIT_IDX_W]][bit_idx[BIT_IDX_W-1:0]];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < int'(NUM_GROUPS); i++) begin
                cfg_mem[i] <= '0;
            end
        end else begin
            rd_valid <= rd_ok;
            err      <= cmd_err;
            if (rd_ok) begin
                rd_data <= cfg_mem[grp_idx];
            end
            if (wr_ok) begin
                cfg_mem[grp_idx] <= data_in;
            end
        end
    end

    ele_shift_tx #(
        .CLK_DIV (CLK_DIV),
        .RST_CYC (RST_CYC)
    ) u_shift_tx (
        .clk_50M        (clk_50M),
        .rst_n          (rst_n),
        .start          (start),
        .prb_rst        (data_in[0]),
        .bit_in         (bit_sel),
        .bit_idx        (bit_idx),
        .busy           (busy),
        .done           (done),
        .clk_to_elec    (clk_to_elec),
        .data_to_elec   (data_to_elec),
        .rst_n_to_probe (rst_n_to_probe)
    );

endmodule

// File: tb/tb_ele_cfg_loader.sv
// Scoreboard bench for ele_cfg_loader: a probe shift-register model captures each load and is
// compared against the image expected when the commit was issued.
module tb_ele_cfg_loader;
    import ele_cfg_loader_pkg::*;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b1;

    logic        cmd_valid;
    logic [5:0]  code;
    logic [9:0]  addr;
    logic [15:0] data_in;
    logic [15:0] rd_data;
    logic        rd_valid, busy, done, err, data_to_elec, clk_to_elec, rst_n_to_probe;

    logic        c1_valid;
    logic [5:0]  c1_code;
    logic [9:0]  c1_addr;
    logic [15:0] c1_data;
    logic [15:0] rd_data1;
    logic        rd_valid1, busy1, done1, err1, data1, clk1, rstp1;

    ele_cfg_loader #(.CLK_DIV(4), .RST_CYC(8)) u_dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .cmd_valid(cmd_valid), .code(code), .addr(addr),
        .data_in(data_in), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .err(err), .data_to_elec(data_to_elec), .clk_to_elec(clk_to_elec),
        .rst_n_to_probe(rst_n_to_probe)
    );

    ele_cfg_loader #(.CLK_DIV(1), .RST_CYC(8)) u_dut_div1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .cmd_valid(c1_valid), .code(c1_code),
        .addr(c1_addr), .data_in(c1_data), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy(busy1), .done(done1), .err(err1), .data_to_elec(data1), .clk_to_elec(clk1),
        .rst_n_to_probe(rstp1)
    );

    initial forever #10 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0]   mem [64];
    logic [15:0]   rd_q [$];
    logic [1023:0] img_q [$];
    int            dur_q [$];
    int            rl_q [$];

    logic [1023:0] probe = '0;
    int edge_cnt = 0, rst_low = 0, rl_at_edge = 0, start_cyc = 0, viol0 = 0;
    int e1 = 0, hi1 = 0, s1 = 0, viol1 = 0, done1_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1023:0] flat_img();
        logic [1023:0] v;
        for (int g = 0; g < 64; g++) v[g*16 +: 16] = mem[g];
        return v;
    endfunction

    initial forever begin
        @(posedge clk_50M);
        cyc++;
    end

    initial #5ms begin
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Probe model and scoreboard consumer for the CLK_DIV=4 instance.
    initial begin
        logic busy_p = 1'b0, clk_p = 1'b0, data_p = 1'b0;
        logic [1023:0] exp_img;
        logic [15:0] exp_rd;
        int ed, erl;
        forever begin
            @(negedge clk_50M);
            if (busy && !busy_p) begin
                edge_cnt = 0; rst_low = 0; rl_at_edge = 0; start_cyc = cyc;
            end
            if (!rst_n_to_probe) rst_low++;
            if (clk_to_elec && !clk_p) begin
                if (edge_cnt == 0) rl_at_edge = rst_low;
                probe = {data_to_elec, probe[1023:1]};
                edge_cnt++;
            end
            if (clk_to_elec && (data_to_elec != data_p)) viol0++;
            if (done) begin
                check_eq("done_expected", 64'(img_q.size() != 0), 1);
                if (img_q.size() != 0) begin
                    exp_img = img_q.pop_front();
                    ed      = dur_q.pop_front();
                    erl     = rl_q.pop_front();
                    for (int c = 0; c < 16; c++)
                        check_eq("probe_img", probe[c*64 +: 64], exp_img[c*64 +: 64]);
                    check_eq("edge_count", edge_cnt, 1024);
                    check_eq("load_cycles", cyc - start_cyc, ed);
                    check_eq("prb_rst_low", rl_at_edge, erl);
                    check_eq("busy_at_done", busy, 0);
                    check_eq("clk_at_done", clk_to_elec, 0);
                    check_eq("data_at_done", data_to_elec, 0);
                end
            end
            if (rd_valid) begin
                check_eq("rd_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    exp_rd = rd_q.pop_front();
                    check_eq("rd_data", rd_data, exp_rd);
                end
            end
            busy_p = busy; clk_p = clk_to_elec; data_p = data_to_elec;
        end
    end

    // Timing monitor for the CLK_DIV=1 instance.
    initial begin
        logic busy_p = 1'b0, clk_p = 1'b0, data_p = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (busy1 && !busy_p) begin
                e1 = 0; hi1 = 0; s1 = cyc;
            end
            if (clk1 && !clk_p) e1++;
            if (clk1) hi1++;
            if (clk1 && (data1 != data_p)) viol1++;
            if (done1) begin
                done1_seen++;
                check_eq("edge_count_div1", e1, 1024);
                check_eq("hi_cycles_div1", hi1, 1024);
                check_eq("load_cycles_div1", cyc - s1, 2049);
            end
            busy_p = busy1; clk_p = clk1; data_p = data1;
        end
    end

    task automatic send_cmd(input logic [5:0] c, input logic [9:0] a, input logic [15:0] d,
                            input bit exp_err);
        code = c; addr = a; data_in = d; cmd_valid = 1'b1;
        @(negedge clk_50M);
        cmd_valid = 1'b0;
        check_eq("err", err, exp_err);
    endtask

    task automatic wr(input int idx, input logic [15:0] d, input bit exp_err);
        if (!exp_err) mem[idx] = d;
        send_cmd(CODE_WR, BASE_ADDR + 10'(idx), d, exp_err);
    endtask

    task automatic rd(input int idx, input bit exp_err);
        if (!exp_err) rd_q.push_back(mem[idx]);
        send_cmd(CODE_RD, BASE_ADDR + 10'(idx), 16'h0, exp_err);
        if (exp_err) check_eq("rd_valid_rej", rd_valid, 0);
    endtask

    task automatic commit(input bit prb, input bit expect_done);
        if (expect_done) begin
            img_q.push_back(flat_img());
            dur_q.push_back(prb ? 8201 : 8193);
            rl_q.push_back(prb ? 8 : 0);
        end
        send_cmd(CODE_COMMIT, BASE_ADDR, {15'h0, prb}, 1'b0);
        check_eq("busy_after_commit", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk_50M);
            n++;
        end
        check_eq("load_timeout", 64'(n < 20000), 1);
        @(negedge clk_50M);
    endtask

    task automatic send1(input logic [5:0] c, input logic [9:0] a, input logic [15:0] d);
        c1_code = c; c1_addr = a; c1_data = d; c1_valid = 1'b1;
        @(negedge clk_50M);
        c1_valid = 1'b0;
        check_eq("err_div1", err1, 0);
    endtask

    initial begin
        int n;
        cmd_valid = 1'b0; code = '0; addr = '0; data_in = '0;
        c1_valid = 1'b0; c1_code = '0; c1_addr = '0; c1_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_data", data_to_elec, 0);
        check_eq("rst_clk", clk_to_elec, 0);
        check_eq("rst_probe", rst_n_to_probe, 1);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // Corner bits: element 0 and element 1023 only.
        wr(0, 16'h0001, 0);
        wr(63, 16'h8000, 0);
        commit(0, 1);
        wait_idle();

        // Incrementing pattern with probe reset; reads and rejected commands mid-load.
        for (int k = 0; k < 64; k++) wr(k, 16'(k), 0);
        wr(5, 16'hA5C3, 0);
        rd(5, 0);
        commit(1, 1);
        repeat (200) @(negedge clk_50M);
        rd(5, 0);
        wr(7, 16'hFFFF, 1);
        send_cmd(CODE_COMMIT, BASE_ADDR, 16'h0, 1);
        wr(64, 16'h1234, 1);
        check_eq("busy_mid_load", busy, 1);
        wait_idle();

        // Range boundaries and unknown opcode while idle.
        wr(64, 16'h1234, 1);
        rd(64, 1);
        send_cmd(CODE_WR, BASE_ADDR - 10'd1, 16'h1234, 1);
        wr(63, 16'h0F0F, 0);
        rd(63, 0);
        send_cmd(6'h3F, BASE_ADDR, 16'h0001, 0);
        check_eq("unknown_op_idle", busy, 0);

        // Abort a load with rst_n at the 300th probe edge.
        commit(0, 0);
        n = 0;
        while (edge_cnt < 300 && n < 20000) begin
            @(negedge clk_50M);
            n++;
        end
        check_eq("abort_wait_timeout", 64'(n < 20000), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_clk", clk_to_elec, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_probe_rst", rst_n_to_probe, 1);
        check_eq("abort_data", data_to_elec, 0);
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
        rd(0, 0);
        rd(63, 0);
        repeat (2) @(negedge clk_50M);

        // CLK_DIV=1 instance: alternating data stresses the hold-while-high property.
        for (int k = 0; k < 4; k++) send1(CODE_WR, BASE_ADDR + 10'(k), 16'hAAAA);
        send1(CODE_COMMIT, BASE_ADDR, 16'h0);
        n = 0;
        while (busy1 && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
        check_eq("div1_timeout", 64'(n < 5000), 1);
        @(negedge clk_50M);

        check_eq("done_div1_count", done1_seen, 1);
        check_eq("hold_div4", viol0, 0);
        check_eq("hold_div1", viol1, 0);
        check_eq("rd_q_empty", rd_q.size(), 0);
        check_eq("img_q_empty", img_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
